// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/flag in, strobes out.
interface control_unit_if;
  logic [5:0] Opcode;
  logic       zero;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic       wez;
  logic [2:0] ALUOp;
  logic       pc_en;
  logic       halted;

  modport master (
    input  Opcode,
    input  zero,
    output s_inc,
    output s_inm,
    output we,
    output wez,
    output ALUOp,
    output pc_en,
    output halted
  );

  modport slave (
    output Opcode,
    output zero,
    input  s_inc,
    input  s_inm,
    input  we,
    input  wez,
    input  ALUOp,
    input  pc_en,
    input  halted
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/EXEC sequencer for the microcontroller datapath,
// with WAIT stall and terminal HALT instructions.
module control_unit #(
  parameter int WAIT_CYCLES = 8,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  control_unit_if.master cu
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    I_ALU,
    I_LI,
    I_J,
    I_JZ,
    I_JNZ,
    I_NOP,
    I_WAIT,
    I_HALT
  } instr_e;

  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  instr_e        instr;

  // 001100 and 001111 both fall through to NOP
  always_comb begin
    instr = I_NOP;
    unique case (1'b1)
      cu.Opcode[5]:               instr = I_ALU;
      cu.Opcode[5:4] == 2'b01:    instr = I_LI;
      cu.Opcode[5:2] == 4'b0000:  instr = I_J;
      cu.Opcode[5:2] == 4'b0001:  instr = I_JZ;
      cu.Opcode[5:2] == 4'b0010:  instr = I_JNZ;
      cu.Opcode == 6'b001101:     instr = I_WAIT;
      cu.Opcode == 6'b001110:     instr = I_HALT;
      default:                    instr = I_NOP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (instr)
          I_WAIT: begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
          I_HALT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_FETCH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset overrides the decode so the datapath sees idle strobes at once
  always_comb begin
    cu.s_inc  = 1'b0;
    cu.s_inm  = 1'b0;
    cu.we     = 1'b0;
    cu.wez    = 1'b0;
    cu.ALUOp  = 3'b000;
    cu.pc_en  = 1'b0;
    cu.halted = 1'b0;
    if (reset) begin
      cu.s_inc = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: cu.s_inc = 1'b1;
        S_EXEC: begin
          cu.pc_en = 1'b1;
          unique case (instr)
            I_ALU: begin
              cu.s_inc = 1'b1;
              cu.we    = 1'b1;
              cu.wez   = 1'b1;
              cu.ALUOp = cu.Opcode[4:2];
            end
            I_LI: begin
              cu.s_inc = 1'b1;
              cu.s_inm = 1'b1;
              cu.we    = 1'b1;
            end
            I_J:     cu.s_inc = 1'b0;
            I_JZ:    cu.s_inc = ~cu.zero;
            I_JNZ:   cu.s_inc = cu.zero;
            I_WAIT:  cu.s_inc = 1'b1;
            I_HALT:  cu.pc_en = 1'b0;
            default: cu.s_inc = 1'b1;
          endcase
        end
        S_HALT:  cu.halted = 1'b1;
        default: cu.s_inc = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected strobe vectors are queued
// as stimulus is driven and compared on the falling edge.
module tb_control_unit;

  typedef struct {
    logic       rst;
    logic       st;
    logic [5:0] op;
    logic       z;
    logic [8:0] exp;
  } vec_t;

  // {s_inc, s_inm, we, wez, ALUOp[2:0], pc_en, halted}
  localparam logic [8:0] O_IDLE = 9'b1_0_0_0_000_0_0;
  localparam logic [8:0] O_ZERO = 9'b0_0_0_0_000_0_0;
  localparam logic [8:0] O_HALT = 9'b0_0_0_0_000_0_1;
  localparam logic [8:0] O_NOP  = 9'b1_0_0_0_000_1_0;
  localparam logic [8:0] O_JT   = 9'b0_0_0_0_000_1_0;
  localparam logic [8:0] O_LI   = 9'b1_1_1_0_000_1_0;

  logic clk;
  logic reset;
  logic start;
  int   total;
  int   bad;
  logic [8:0] sb[$];

  control_unit_if bus ();

  control_unit #(
    .WAIT_CYCLES(3),
    .CW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cu(bus)
  );

  wire [8:0] obs = {bus.s_inc, bus.s_inm, bus.we, bus.wez,
                    bus.ALUOp, bus.pc_en, bus.halted};

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic [5:0] o,
                              logic z, logic [8:0] e);
    vec_t v;
    v.rst = r;
    v.st  = s;
    v.op  = o;
    v.z   = z;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [8:0] alu_exp(logic [2:0] a);
    return {1'b1, 1'b0, 1'b1, 1'b1, a, 1'b1, 1'b0};
  endfunction

  // Reference decode of the EXEC cycle for non-WAIT, non-HALT opcodes
  function automatic logic [8:0] exec_exp(logic [5:0] o, logic z);
    if (o[5])               return alu_exp(o[4:2]);
    if (o[5:4] == 2'b01)    return O_LI;
    if (o[5:2] == 4'b0000)  return O_JT;
    if (o[5:2] == 4'b0001)  return z ? O_JT : O_NOP;
    if (o[5:2] == 4'b0010)  return z ? O_NOP : O_JT;
    return O_NOP;
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic run(input string name, input vec_t v[$]);
    foreach (v[i]) begin
      reset      = v[i].rst;
      start      = v[i].st;
      bus.Opcode = v[i].op;
      bus.zero   = v[i].z;
      sb.push_back(v[i].exp);
    end
  endtask

  task automatic test_reset();
    vec_t v[$];
    logic [8:0] e;
    for (int i = 0; i < 3; i++) v.push_back(mk(1, 0, rnd_op(), 0, O_IDLE));
    for (int i = 0; i < 2; i++) v.push_back(mk(0, 0, rnd_op(), 1, O_IDLE));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_idle_no_start();
    vec_t v[$];
    logic [8:0] e;
    for (int i = 0; i < 20; i++) v.push_back(mk(0, 0, rnd_op(), i[0], O_IDLE));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL idle[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_imm();
    vec_t v[$];
    logic [8:0] e;
    v.push_back(mk(0, 1, 6'b000000, 0, O_IDLE));
    v.push_back(mk(0, 0, 6'b010101, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b010101, 0, O_LI));
    v.push_back(mk(0, 1, 6'b011111, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b011111, 1, O_LI));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL load_imm[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    vec_t v[$];
    logic [8:0] e;
    v.push_back(mk(0, 0, 6'b101101, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b101101, 0, alu_exp(3'b011)));
    v.push_back(mk(0, 0, 6'b111111, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b111111, 1, alu_exp(3'b111)));
    v.push_back(mk(0, 0, 6'b100010, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b100010, 0, alu_exp(3'b000)));
    v.push_back(mk(0, 0, 6'b110000, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b110000, 1, alu_exp(3'b100)));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL alu[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    vec_t v[$];
    logic [8:0] e;
    logic [5:0] ops[6];
    logic       zs[6];
    logic [8:0] ex[6];
    ops = '{6'b000110, 6'b000110, 6'b001001, 6'b001001, 6'b000011, 6'b000000};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ex  = '{O_JT, O_NOP, O_NOP, O_JT, O_JT, O_JT};
    for (int k = 0; k < 6; k++) begin
      v.push_back(mk(0, 0, rnd_op(), zs[k], O_ZERO));
      v.push_back(mk(0, 0, ops[k], zs[k], ex[k]));
    end
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL jumps[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nop();
    vec_t v[$];
    logic [8:0] e;
    v.push_back(mk(0, 0, 6'b001100, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b001100, 0, O_NOP));
    v.push_back(mk(0, 0, 6'b001111, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b001111, 1, O_NOP));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL nop[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait();
    vec_t v[$];
    logic [8:0] e;
    v.push_back(mk(0, 0, 6'b001101, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b001101, 0, O_NOP));
    v.push_back(mk(0, 0, 6'b010001, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b101101, 0, O_ZERO));
    v.push_back(mk(0, 1, 6'b001110, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b010011, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b010011, 0, O_LI));
    v.push_back(mk(0, 0, 6'b001101, 1, O_ZERO));
    v.push_back(mk(0, 0, 6'b001101, 1, O_NOP));
    v.push_back(mk(0, 0, 6'b100000, 0, O_ZERO));
    v.push_back(mk(1, 0, 6'b100000, 0, O_IDLE));
    v.push_back(mk(0, 0, 6'b100000, 0, O_IDLE));
    v.push_back(mk(0, 1, 6'b100000, 0, O_IDLE));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL wait[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [8:0] e;
    logic [5:0] o;
    logic       z;
    for (int k = 0; k < 30; k++) begin
      o = rnd_op();
      while (o == 6'b001101 || o == 6'b001110) o = rnd_op();
      z = 1'($urandom_range(0, 1));
      v.push_back(mk(0, 0, rnd_op(), z, O_ZERO));
      v.push_back(mk(0, 0, o, z, exec_exp(o, z)));
    end
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL b2b[%0d] op=%b got=%b want=%b", i, v[i].op, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    vec_t v[$];
    logic [8:0] e;
    v.push_back(mk(0, 0, 6'b001110, 0, O_ZERO));
    v.push_back(mk(0, 0, 6'b001110, 0, O_ZERO));
    for (int k = 0; k < 10; k++)
      v.push_back(mk(0, k[0], rnd_op(), k[1], O_HALT));
    v.push_back(mk(1, 1, 6'b001110, 0, O_IDLE));
    v.push_back(mk(0, 0, 6'b001110, 0, O_IDLE));
    v.push_back(mk(0, 0, 6'b001110, 0, O_IDLE));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st;
      bus.Opcode = v[i].op; bus.zero = v[i].z;
      sb.push_back(v[i].exp);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL halt[%0d] got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    bus.Opcode = 6'b000000;
    bus.zero   = 1'b0;
    total      = 0;
    bad        = 0;
    test_reset();
    test_idle_no_start();
    test_load_imm();
    test_alu();
    test_jumps();
    test_nop();
    test_wait();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
